// File: rtl/exchange_sequencer.sv
// Multi-cycle sequencer for Exm (reg<->mem) and Exr (reg<->reg) swaps.
// Define EXCH_MEM_WAIT_EN to add the mem_ready handshake on the Exm steps.
module exchange_sequencer #(
    parameter int          CNT_W  = 16,
    parameter logic [5:0]  OP_EXM = 6'b000011,
    parameter logic [5:0]  OP_EXR = 6'b000100
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [5:0]       opcode,
`ifdef EXCH_MEM_WAIT_EN
    input  logic             mem_ready,
`endif
    output logic             ready,
    output logic             stall,
    output logic             done,
    output logic             RegWrite,
    output logic             ExrWrite,
    output logic             RdReg2,
    output logic             MemWrite,
    output logic             MemRead,
    output logic [1:0]       RdReg1,
    output logic [1:0]       WrData,
    output logic [1:0]       WrReg,
    output logic [CNT_W-1:0] exch_count
);

    typedef enum logic [2:0] {
        IDLE,
        EXM_RD,
        EXM_WR,
        EXR_RD,
        EXR_W1,
        EXR_W2
    } state_t;

    typedef struct packed {
        logic       reg_write;
        logic       exr_write;
        logic       rd_reg2;
        logic       mem_write;
        logic       mem_read;
        logic       done;
        logic [1:0] rd_reg1;
        logic [1:0] wr_data;
        logic [1:0] wr_reg;
    } outs_t;

    state_t           state_q, state_d;
    outs_t            outs_q, outs_d;
    logic             ready_q, ready_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             mem_ok;
    logic             is_exch;
    logic             retire;

`ifdef EXCH_MEM_WAIT_EN
    assign mem_ok = mem_ready;
`else
    assign mem_ok = 1'b1;
`endif

    assign is_exch = (opcode == OP_EXM) || (opcode == OP_EXR);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start && opcode == OP_EXM) begin
                    state_d = EXM_RD;
                end else if (start && opcode == OP_EXR) begin
                    state_d = EXR_RD;
                end
            end
            EXM_RD:  if (mem_ok) state_d = EXM_WR;
            EXM_WR:  if (mem_ok) state_d = IDLE;
            EXR_RD:  state_d = EXR_W1;
            EXR_W1:  state_d = EXR_W2;
            EXR_W2:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they are registered
    // alongside it and line up with the state they describe.
    always_comb begin
        outs_d  = '0;
        ready_d = (state_d == IDLE);
        unique case (state_d)
            EXM_RD: begin
                outs_d.mem_read = 1'b1;
            end
            EXM_WR: begin
                outs_d.mem_write = 1'b1;
                outs_d.reg_write = 1'b1;
                outs_d.wr_data   = 2'b10;
                outs_d.done      = 1'b1;
            end
            EXR_RD: begin
                outs_d.rd_reg2 = 1'b1;
                outs_d.rd_reg1 = 2'b01;
            end
            EXR_W1: begin
                outs_d.reg_write = 1'b1;
                outs_d.exr_write = 1'b1;
                outs_d.rd_reg2   = 1'b1;
                outs_d.rd_reg1   = 2'b01;
                outs_d.wr_data   = 2'b10;
            end
            EXR_W2: begin
                outs_d.reg_write = 1'b1;
                outs_d.rd_reg2   = 1'b1;
                outs_d.rd_reg1   = 2'b11;
                outs_d.wr_reg    = 2'b10;
                outs_d.done      = 1'b1;
            end
            default: outs_d = '0;
        endcase
    end

    assign retire  = ((state_q == EXM_WR) && mem_ok) || (state_q == EXR_W2);
    assign count_d = count_q + (retire ? {{(CNT_W-1){1'b0}}, 1'b1} : '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            outs_q  <= '0;
            ready_q <= 1'b1;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            outs_q  <= outs_d;
            ready_q <= ready_d;
            count_q <= count_d;
        end
    end

    // Fetch must hold already in the issue cycle, hence the start term.
    assign stall = !ready_q || (start && is_exch);

    assign ready      = ready_q;
    assign done       = outs_q.done;
    assign RegWrite   = outs_q.reg_write;
    assign ExrWrite   = outs_q.exr_write;
    assign RdReg2     = outs_q.rd_reg2;
    assign MemWrite   = outs_q.mem_write;
    assign MemRead    = outs_q.mem_read;
    assign RdReg1     = outs_q.rd_reg1;
    assign WrData     = outs_q.wr_data;
    assign WrReg      = outs_q.wr_reg;
    assign exch_count = count_q;

endmodule

// File: tb/tb_exchange_sequencer.sv
// Self-checking bench for exchange_sequencer: per-cycle schedule model
// plus directed literal checks.
module tb_exchange_sequencer;

    localparam logic [5:0] EXM = 6'b000011;
    localparam logic [5:0] EXR = 6'b000100;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [5:0]  opcode;
    logic        ready, stall, done;
    logic        RegWrite, ExrWrite, RdReg2, MemWrite, MemRead;
    logic [1:0]  RdReg1, WrData, WrReg;
    logic [15:0] exch_count;
`ifdef EXCH_MEM_WAIT_EN
    logic        mem_ready = 1'b1;
`endif

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    exchange_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .opcode     (opcode),
`ifdef EXCH_MEM_WAIT_EN
        .mem_ready  (mem_ready),
`endif
        .ready      (ready),
        .stall      (stall),
        .done       (done),
        .RegWrite   (RegWrite),
        .ExrWrite   (ExrWrite),
        .RdReg2     (RdReg2),
        .MemWrite   (MemWrite),
        .MemRead    (MemRead),
        .RdReg1     (RdReg1),
        .WrData     (WrData),
        .WrReg      (WrReg),
        .exch_count (exch_count)
    );

    // ready, RegWrite, ExrWrite, RdReg2, MemWrite, MemRead, done,
    // RdReg1, WrData, WrReg
    typedef logic [12:0] vec_t;

    function automatic vec_t mk(input logic rdy, rw, ew, r2, mw, mr, dn,
                                input logic [1:0] rd1, wd, wr);
        return {rdy, rw, ew, r2, mw, mr, dn, rd1, wd, wr};
    endfunction

    vec_t v_idle, v_exm_rd, v_exm_wr, v_exr_rd, v_exr_w1, v_exr_w2;
    initial begin
        v_idle   = mk(1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00);
        v_exm_rd = mk(0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00);
        v_exm_wr = mk(0, 1, 0, 0, 1, 0, 1, 2'b00, 2'b10, 2'b00);
        v_exr_rd = mk(0, 0, 0, 1, 0, 0, 0, 2'b01, 2'b00, 2'b00);
        v_exr_w1 = mk(0, 1, 1, 1, 0, 0, 0, 2'b01, 2'b10, 2'b00);
        v_exr_w2 = mk(0, 1, 0, 1, 0, 0, 1, 2'b11, 2'b00, 2'b10);
    end

    // Model: an accepted issue schedules its step vectors into a queue.
    vec_t q[$];
    vec_t cur;
    int   mcnt;
    bit   hold;

    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            cur  = v_idle;
            mcnt = 0;
        end else begin
            hold = 1'b0;
`ifdef EXCH_MEM_WAIT_EN
            hold = (cur[8] || cur[7]) && !mem_ready;
`endif
            if (!hold) begin
                if (cur[6]) mcnt = (mcnt + 1) % 65536;
                if (q.size() > 0) begin
                    cur = q.pop_front();
                end else if (cur[12] && start && opcode == EXM) begin
                    q.push_back(v_exm_wr);
                    cur = v_exm_rd;
                end else if (cur[12] && start && opcode == EXR) begin
                    q.push_back(v_exr_w1);
                    q.push_back(v_exr_w2);
                    cur = v_exr_rd;
                end else begin
                    cur = v_idle;
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d @%0t", name, act, exp,
                     $time);
        end
    endtask

    vec_t act_v;
    bit   exp_stall;
    always @(negedge clk) begin
        if (chk_en) begin
            act_v = {ready, RegWrite, ExrWrite, RdReg2, MemWrite, MemRead,
                     done, RdReg1, WrData, WrReg};
            exp_stall = !cur[12] ||
                        (start && (opcode == EXM || opcode == EXR));
            chk("outs", int'(act_v), int'(cur));
            chk("stall", int'(stall), int'(exp_stall));
            chk("count", int'(exch_count), mcnt);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [5:0] op);
        start  = 1'b1;
        opcode = op;
    endtask

    task automatic idle_in();
        start  = 1'b0;
        opcode = 6'd0;
    endtask

    logic [5:0] table_ops [8];
    int         mr_cycles;

    initial begin
        table_ops = '{EXR, 6'd0, EXM, 6'b111111, EXR, EXM, 6'd5, EXM};
        rst = 1'b1;
        idle_in();
        tick();
        tick();
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_ready", int'(ready), 1);
        chk("rst_stall", int'(stall), 0);
        chk("rst_count", int'(exch_count), 0);
        chk("rst_regwrite", int'(RegWrite), 0);
        rst = 1'b0;
        tick();

        // Exm
        issue(EXM);
        @(negedge clk);
        chk("exm_k_stall", int'(stall), 1);
        tick();
        idle_in();
        @(negedge clk);
        chk("exm_k1_memread", int'(MemRead), 1);
        tick();
        @(negedge clk);
        chk("exm_k2_memwrite", int'(MemWrite), 1);
        chk("exm_k2_regwrite", int'(RegWrite), 1);
        chk("exm_k2_wrdata", int'(WrData), 2);
        chk("exm_k2_done", int'(done), 1);
        tick();
        @(negedge clk);
        chk("exm_k3_ready", int'(ready), 1);
        chk("exm_k3_stall", int'(stall), 0);
        chk("exm_k3_count", int'(exch_count), 1);

        // Two Exr back to back
        issue(EXR);
        tick();
        idle_in();
        @(negedge clk);
        chk("exr_k1_rdreg1", int'(RdReg1), 1);
        tick();
        @(negedge clk);
        chk("exr_k2_exrwrite", int'(ExrWrite), 1);
        tick();
        @(negedge clk);
        chk("exr_k3_wrreg", int'(WrReg), 2);
        chk("exr_k3_stall", int'(stall), 1);
        tick();
        issue(EXR);
        @(negedge clk);
        chk("exr_k4_ready", int'(ready), 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            idle_in();
        end
        @(negedge clk);
        chk("exr_b2b_count", int'(exch_count), 3);

        // Non-exchange opcode is ignored
        issue(6'd0);
        @(negedge clk);
        chk("nop_stall", int'(stall), 0);
        tick();
        idle_in();
        @(negedge clk);
        chk("nop_ready", int'(ready), 1);

        // start during EXR_W1 is ignored
        issue(EXR);
        tick();
        idle_in();
        tick();
        issue(EXM);
        tick();
        idle_in();
        @(negedge clk);
        chk("ign_w2_rdreg1", int'(RdReg1), 3);
        tick();
        @(negedge clk);
        chk("ign_idle_ready", int'(ready), 1);
        chk("ign_count", int'(exch_count), 4);

        // Reset in EXR_W1 abandons the exchange
        issue(EXR);
        tick();
        idle_in();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rstmid_regwrite", int'(RegWrite), 0);
        chk("rstmid_ready", int'(ready), 1);
        chk("rstmid_count", int'(exch_count), 0);

        // Mixed opcode table, one start per idle slot
        for (int i = 0; i < 8; i++) begin
            issue(table_ops[i]);
            tick();
            idle_in();
            while (!ready) tick();
        end
        tick();
        @(negedge clk);
        chk("table_count", int'(exch_count), 5);

`ifdef EXCH_MEM_WAIT_EN
        issue(EXM);
        mem_ready = 1'b0;
        tick();
        idle_in();
        mr_cycles = 0;
        for (int i = 0; i < 6; i++) begin
            if (i == 3) mem_ready = 1'b1;
            @(negedge clk);
            if (MemRead) mr_cycles++;
            tick();
        end
        chk("wait_memread_cycles", mr_cycles, 4);
        chk("wait_count", int'(exch_count), 6);
`else
        mr_cycles = 0;
`endif

        tick();
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
